mash_pwm_out: RTL

- Final combiner and PWM generator at the tail of the ANS-PWM noise-shaping cascade.
- Takes the sign-magnitude correction outputs of four quantize/ddiff stages (C/Csgn style), forms their signed sum, offsets and saturates it to a duty value, and buffers it one deep.
- Loads the duty at PWM frame boundaries and drives the single-bit PWM output.

---
 rtl/mash_pwm_out.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mash_pwm_out.sv
// Sums four sign-magnitude stage corrections plus a bias, clamps the result to a PWM duty,
// and holds it in a one-deep pending slot that is swapped into the PWM generator at frame end.
module mash_pwm_out #(
  parameter int PWM_BITS = 8,
  parameter int OFFSET   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] mag0,
  input  logic [15:0] mag1,
  input  logic [15:0] mag2,
  input  logic [15:0] mag3,
  input  logic        sgn0,
  input  logic        sgn1,
  input  logic        sgn2,
  input  logic        sgn3,
  input  logic [3:0]  stage_en,
  input  logic        clr_flags,
  output logic        pwm_out,
  output logic        frame_start,
  output logic        sat_flag,
  output logic        underrun_flag
);

  localparam int DW = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic signed [19:0] SUM_MAX = 20'(1 << PWM_BITS);
  localparam logic signed [19:0] SUM_OFF = 20'(OFFSET);

  logic [15:0]        mag_a [4];
  logic [3:0]         sgn_a;
  logic signed [16:0] term  [4];
  logic signed [19:0] sum_s;
  logic [DW-1:0]      duty;
  logic               sat;
  logic               accept;
  logic               frame_end;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pend_full_q, pend_full_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic [DW-1:0]       duty_active_q, duty_active_d;
  logic                primed_q, primed_d;
  logic                pwm_q, pwm_d;
  logic                fs_q, fs_d;
  logic                sat_q, sat_d;
  logic                und_q, und_d;

  always_comb begin
    mag_a[0] = mag0;
    mag_a[1] = mag1;
    mag_a[2] = mag2;
    mag_a[3] = mag3;
    sgn_a    = {sgn3, sgn2, sgn1, sgn0};
    for (int i = 0; i < 4; i++) begin
      term[i] = '0;
      if (stage_en[i]) begin
        term[i] = sgn_a[i] ? -$signed({1'b0, mag_a[i]}) : $signed({1'b0, mag_a[i]});
      end
    end
  end

  // 20 bits holds four full-scale 17-bit terms plus the bias without wrapping.
  always_comb begin
    sum_s = SUM_OFF + 20'(term[0]) + 20'(term[1]) + 20'(term[2]) + 20'(term[3]);
    duty  = sum_s[DW-1:0];
    sat   = 1'b0;
    if (sum_s < 0) begin
      duty = '0;
      sat  = 1'b1;
    end else if (sum_s > SUM_MAX) begin
      duty = SUM_MAX[DW-1:0];
      sat  = 1'b1;
    end
  end

  assign in_ready  = !pend_full_q;
  assign accept    = in_valid && !pend_full_q;
  assign frame_end = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    pend_full_d   = pend_full_q;
    pending_d     = pending_q;
    duty_active_d = duty_active_q;
    primed_d      = primed_q;
    // Swap and accept cannot coincide: swap needs a full slot, accept an empty one.
    if (frame_end && pend_full_q) begin
      duty_active_d = pending_q;
      pend_full_d   = 1'b0;
      primed_d      = 1'b1;
    end else if (accept) begin
      pending_d   = duty;
      pend_full_d = 1'b1;
    end
    pwm_d = ({1'b0, cnt_q} < duty_active_q);
    fs_d  = frame_end;
    sat_d = (sat_q && !clr_flags) || (accept && sat);
    und_d = (und_q && !clr_flags) || (frame_end && !pend_full_q && primed_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      pend_full_q   <= 1'b0;
      pending_q     <= '0;
      duty_active_q <= '0;
      primed_q      <= 1'b0;
      pwm_q         <= 1'b0;
      fs_q          <= 1'b0;
      sat_q         <= 1'b0;
      und_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pend_full_q   <= pend_full_d;
      pending_q     <= pending_d;
      duty_active_q <= duty_active_d;
      primed_q      <= primed_d;
      pwm_q         <= pwm_d;
      fs_q          <= fs_d;
      sat_q         <= sat_d;
      und_q         <= und_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign frame_start   = fs_q;
  assign sat_flag      = sat_q;
  assign underrun_flag = und_q;

endmodule
